// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential vedic multiplier.
// Provides the digit width, the FSM state encoding and the digit-index width helper.
`timescale 1ns/1ps
package vedic_pkg;

    localparam int DIGIT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // ceil(log2(digits)), never below 1 so index vectors stay legal
    function automatic int idx_w(input int digits);
        int w;
        w = 1;
        for (int k = 0; k < 31; k++) begin
            if ((1 << w) < digits) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational 8x8 unsigned multiplier built from Urdhva-Tiryagbhyam 2x2 cells,
// combined vertically-and-crosswise into 4x4 and then 8x8 stages.
`timescale 1ns/1ps
module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] t;
        logic [1:0] m;
        t = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        m = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
        return {m, t[0], x[0] & y[0]};
    endfunction

    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = {4'b0, v2(x[1:0], y[1:0])};
        q1 = {4'b0, v2(x[3:2], y[1:0])};
        q2 = {4'b0, v2(x[1:0], y[3:2])};
        q3 = {4'b0, v2(x[3:2], y[3:2])};
        return q0 + ((q1 + q2) << 2) + (q3 << 4);
    endfunction

    logic [15:0] q0, q1, q2, q3;

    always_comb begin
        q0 = {8'b0, v4(a[3:0], b[3:0])};
        q1 = {8'b0, v4(a[7:4], b[3:0])};
        q2 = {8'b0, v4(a[3:0], b[7:4])};
        q3 = {8'b0, v4(a[7:4], b[7:4])};
        p  = q0 + ((q1 + q2) << 4) + (q3 << 8);
    end

endmodule

// File: rtl/vedic_seq_mul.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one vedic_8x8 core, one byte pair per cycle.
// Define VEDIC_SEQ_EARLY_ZERO_EN to skip the RUN phase when either operand is zero.
`timescale 1ns/1ps
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int IW     = idx_w(DIGITS);
    localparam int PW     = 2 * WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;

    logic [DIGIT_W-1:0]   a_dig, b_dig;
    logic [2*DIGIT_W-1:0] core_p;
    logic [PW-1:0]        pp_shift;
    logic                 last_step;
    logic                 zero_op;

    vedic_8x8 u_core (
        .a (a_dig),
        .b (b_dig),
        .p (core_p)
    );

`ifdef VEDIC_SEQ_EARLY_ZERO_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        a_dig     = a_q[DIGIT_W*int'(i_q) +: DIGIT_W];
        b_dig     = b_q[DIGIT_W*int'(j_q) +: DIGIT_W];
        pp_shift  = {{(PW-2*DIGIT_W){1'b0}}, core_p} << (DIGIT_W * (int'(i_q) + int'(j_q)));
        last_step = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + pp_shift;
                // j is the inner digit; i advances when j wraps
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
        p         = acc_q;
    end

endmodule
